// File: rtl/shifter_iter.sv
`default_nettype none
// ============================================================================
// Module      : shifter_iter
// Description : Iterative shift/rotate register, one bit position per clock,
//               with a start/ready/done handshake. Ops: NOP, LOAD, LSL, LSR,
//               ASR, ROL, ROR (code 111 behaves as NOP).
//               Optional macro SHIFTER_ITER_CARRY_EN adds a 'carry' output
//               that holds the bit shifted or rotated out on the final step.
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_iter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   d_in,
  output logic [WIDTH-1:0]   d_out,
  output logic               ready,
  output logic               done
`ifdef SHIFTER_ITER_CARRY_EN
  ,
  output logic               carry
`endif
);

  localparam logic [2:0]         c_OP_LOAD = 3'b001;
  localparam logic [2:0]         c_OP_LSL  = 3'b010;
  localparam logic [2:0]         c_OP_LSR  = 3'b011;
  localparam logic [2:0]         c_OP_ASR  = 3'b100;
  localparam logic [2:0]         c_OP_ROL  = 3'b101;
  localparam logic [2:0]         c_OP_ROR  = 3'b110;
  localparam logic [SHAMT_W-1:0] c_ONE     = SHAMT_W'(1);
  localparam logic [SHAMT_W-1:0] c_ZERO    = '0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  logic [SHAMT_W-1:0] r_count;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_data;
  logic               r_ready;
  logic               r_done;

  logic               w_is_shift;
  logic [2:0]         w_step_op;
  logic [WIDTH-1:0]   w_step_data;

  // One 1-bit step of the selected shift/rotate; non-shift codes hold value.
  function automatic logic [WIDTH-1:0] f_step(input logic [2:0] o,
                                              input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] res;
    res = v;
    case (o)
      c_OP_LSL: res = {v[WIDTH-2:0], 1'b0};
      c_OP_LSR: res = {1'b0, v[WIDTH-1:1]};
      c_OP_ASR: res = {v[WIDTH-1], v[WIDTH-1:1]};
      c_OP_ROL: res = {v[WIDTH-2:0], v[WIDTH-1]};
      c_OP_ROR: res = {v[0], v[WIDTH-1:1]};
      default:  res = v;
    endcase
    return res;
  endfunction

`ifdef SHIFTER_ITER_CARRY_EN
  logic r_carry;
  logic w_step_carry;

  // Bit leaving the register on a step: msb for left moves, lsb otherwise.
  function automatic logic f_carry(input logic [2:0] o,
                                   input logic [WIDTH-1:0] v);
    logic c;
    if (o == c_OP_LSL || o == c_OP_ROL) c = v[WIDTH-1];
    else                                c = v[0];
    return c;
  endfunction
`endif

  // Shift ops are 010..110; NOP, LOAD and reserved 111 complete in one cycle.
  assign w_is_shift  = (op >= c_OP_LSL) && (op <= c_OP_ROR);
  // The first step uses the live op at accept; later steps use the latched op.
  assign w_step_op   = (r_state == ST_BUSY) ? r_op : op;
  assign w_step_data = f_step(w_step_op, r_data);
`ifdef SHIFTER_ITER_CARRY_EN
  assign w_step_carry = f_carry(w_step_op, r_data);
`endif

  // Control FSM and datapath register; all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= c_ZERO;
      r_op    <= 3'b000;
      r_data  <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
`ifdef SHIFTER_ITER_CARRY_EN
      r_carry <= 1'b0;
`endif
    end else if (r_state == ST_IDLE) begin
      r_done <= 1'b0;
      if (start) begin
        if (op == c_OP_LOAD) begin
          r_data <= d_in;
`ifdef SHIFTER_ITER_CARRY_EN
          r_carry <= 1'b0;
`endif
          r_done <= 1'b1;
        end else if (w_is_shift && (shamt != c_ZERO)) begin
          // First step happens on the accept edge itself.
          r_data  <= w_step_data;
`ifdef SHIFTER_ITER_CARRY_EN
          r_carry <= w_step_carry;
`endif
          r_count <= shamt - c_ONE;
          r_op    <= op;
          if (shamt == c_ONE) begin
            r_done <= 1'b1;
          end else begin
            r_state <= ST_BUSY;
            r_ready <= 1'b0;
          end
        end else begin
          // NOP, reserved op, or zero shift amount: value untouched.
          r_done <= 1'b1;
        end
      end
    end else begin
      // BUSY: count stays >= 1 here, so the final step is at count == 1.
      r_data  <= w_step_data;
`ifdef SHIFTER_ITER_CARRY_EN
      r_carry <= w_step_carry;
`endif
      r_count <= r_count - c_ONE;
      if (r_count == c_ONE) begin
        r_state <= ST_IDLE;
        r_ready <= 1'b1;
        r_done  <= 1'b1;
      end
    end
  end

  assign d_out = r_data;
  assign ready = r_ready;
  assign done  = r_done;
`ifdef SHIFTER_ITER_CARRY_EN
  assign carry = r_carry;
`endif

endmodule
`default_nettype wire
